// File: rtl/keccak_round_ctrl.sv
// Round/slice sequencer for a slice-serial Keccak-f[1600] datapath.
// Walks 24 rounds x {theta, rho-pi, chi, iota} x 64 slices under ready backpressure.
module keccak_round_ctrl #(
  parameter int unsigned NUM_ROUNDS = 24,
  parameter int unsigned NUM_SLICES = 64,
  parameter int unsigned SLICE_W    = 6,
  parameter int unsigned ROUND_W    = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2:0]         phase,
  output logic [SLICE_W-1:0] slice_idx,
  output logic [ROUND_W-1:0] round_idx,
  output logic               step_en,
  output logic               theta_en,
  output logic               rhopi_en,
  output logic               chi_en,
  output logic               iota_en,
  output logic               last_slice
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_THETA = 3'd1,
    ST_RHOPI = 3'd2,
    ST_CHI   = 3'd3,
    ST_IOTA  = 3'd4,
    ST_DONE  = 3'd5
  } phase_e;

  localparam logic [SLICE_W-1:0] LAST_SLICE = SLICE_W'(NUM_SLICES - 1);
  localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS - 1);

  phase_e             phase_q, phase_d;
  logic [SLICE_W-1:0] slice_q, slice_d;
  logic [ROUND_W-1:0] round_q, round_d;

  logic active;
  logic xfer;
  logic at_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= ST_IDLE;
      slice_q <= '0;
      round_q <= '0;
    end else begin
      phase_q <= phase_d;
      slice_q <= slice_d;
      round_q <= round_d;
    end
  end

  always_comb begin
    active  = (phase_q == ST_THETA) || (phase_q == ST_RHOPI) ||
              (phase_q == ST_CHI)   || (phase_q == ST_IOTA);
    xfer    = active && ready;
    at_last = (slice_q == LAST_SLICE);
  end

  always_comb begin
    phase_d = phase_q;
    slice_d = slice_q;
    round_d = round_q;
    unique case (phase_q)
      ST_IDLE: begin
        if (start) begin
          phase_d = ST_THETA;
          slice_d = '0;
          round_d = '0;
        end
      end
      ST_THETA, ST_RHOPI, ST_CHI, ST_IOTA: begin
        // abort wins over a same-edge transfer; the datapath still writes that slice
        if (abort) begin
          phase_d = ST_IDLE;
          slice_d = '0;
          round_d = '0;
        end else if (xfer) begin
          if (at_last) begin
            slice_d = '0;
            unique case (phase_q)
              ST_THETA: phase_d = ST_RHOPI;
              ST_RHOPI: phase_d = ST_CHI;
              ST_CHI:   phase_d = ST_IOTA;
              default: begin
                if (round_q == LAST_ROUND) begin
                  phase_d = ST_DONE;
                end else begin
                  phase_d = ST_THETA;
                  round_d = round_q + 1'b1;
                end
              end
            endcase
          end else begin
            slice_d = slice_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        phase_d = ST_IDLE;
        slice_d = '0;
        round_d = '0;
      end
      default: begin
        phase_d = ST_IDLE;
        slice_d = '0;
        round_d = '0;
      end
    endcase
  end

  always_comb begin
    phase      = phase_q;
    slice_idx  = slice_q;
    round_idx  = round_q;
    busy       = (phase_q != ST_IDLE);
    done       = (phase_q == ST_DONE);
    step_en    = active;
    theta_en   = (phase_q == ST_THETA);
    rhopi_en   = (phase_q == ST_RHOPI);
    chi_en     = (phase_q == ST_CHI);
    iota_en    = (phase_q == ST_IOTA);
    last_slice = active && at_last;
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst) begin
      assert (round_q <= LAST_ROUND);
      assert ($onehot0({theta_en, rhopi_en, chi_en, iota_en}));
    end
  end
`endif

endmodule
